// File: rtl/multadd_dot_seq.sv
// Dot-product sequencer: streams operand quads into an external multiply-add unit and accumulates its results.
// Latency: a quad's result is accumulated MA_LAT cycles after its transfer; oDONE follows the last transfer by MA_LAT+1 cycles.
// Backpressure: oREADY is high only in RUN, so a quad is taken whenever iVALID is high there; gaps stall issue while the pipe drains.
module multadd_dot_seq #(
  parameter int LEN_W  = 8,
  parameter int MA_LAT = 1,
  parameter int ACC_W  = 24
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iSTART,
  input  logic [LEN_W-1:0] iLEN,
  input  logic             iMODE,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic [7:0]       iA0,
  input  logic [7:0]       iA1,
  input  logic [7:0]       iB0,
  input  logic [7:0]       iB1,
  output logic             oMA_SEL,
  output logic [7:0]       oMA_A0,
  output logic [7:0]       oMA_A1,
  output logic [7:0]       oMA_B0,
  output logic [7:0]       oMA_B1,
  input  logic [16:0]      iMA_RES,
  output logic             oBUSY,
  output logic             oDONE,
  output logic [ACC_W-1:0] oACC,
  output logic             oOVF
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [7:0]         a0_q, a0_d;
  logic [7:0]         a1_q, a1_d;
  logic [7:0]         b0_q, b0_d;
  logic [7:0]         b1_q, b1_d;
  logic [MA_LAT-1:0]  pipe_q, pipe_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic               start_acc;
  logic               xfer;
  logic               res_vld;
  logic [LEN_W-1:0]   cnt_inc;
  logic [ACC_W-1:0]   res_ext;
  logic [ACC_W:0]     sum_w;
  logic               add_ovf;

  // A start is honoured only while idle; quads are taken only in RUN.
  assign start_acc = (state_q == S_IDLE) & iSTART;
  assign xfer      = iVALID & (state_q == S_RUN);
  assign cnt_inc   = cnt_q + LEN_W'(1);

  // The oldest in-flight flag marks the cycle in which iMA_RES belongs to an issued quad.
  assign res_vld = pipe_q[MA_LAT-1];

  // Add mode results are unsigned; subtract mode results are 17-bit two's complement.
  assign res_ext = mode_q ? ACC_W'($signed(iMA_RES)) : ACC_W'(iMA_RES);
  assign sum_w   = {1'b0, acc_q} + {1'b0, res_ext};

  // Unsigned carry-out in add mode, signed overflow in subtract mode.
  assign add_ovf = mode_q ? ((acc_q[ACC_W-1] == res_ext[ACC_W-1]) &&
                             (sum_w[ACC_W-1] != acc_q[ACC_W-1]))
                          : sum_w[ACC_W];

  // Next-state logic: a zero-length job skips straight to DONE; DRAIN ends once the pipe empties this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          state_d = (iLEN == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (xfer && (cnt_inc == len_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pipe_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next-state: job latch, issue count, operand registers, in-flight pipe and accumulator.
  always_comb begin
    len_d  = len_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    a0_d   = a0_q;
    a1_d   = a1_q;
    b0_d   = b0_q;
    b1_d   = b1_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    pipe_d = pipe_q << 1;
    pipe_d[0] = xfer;

    if (start_acc) begin
      len_d  = iLEN;
      mode_d = iMODE;
      cnt_d  = '0;
      acc_d  = '0;
      ovf_d  = 1'b0;
    end

    if (xfer) begin
      cnt_d = cnt_inc;
      a0_d  = iA0;
      a1_d  = iA1;
      b0_d  = iB0;
      b1_d  = iB1;
    end

    // The pipe is always empty in IDLE, so this never collides with the start clear.
    if (res_vld) begin
      acc_d = sum_w[ACC_W-1:0];
      if (add_ovf) begin
        ovf_d = 1'b1;
      end
    end
  end

  // State and datapath registers; reset discards any job in flight.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      pipe_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      pipe_q  <= pipe_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oREADY  = (state_q == S_RUN);
  assign oBUSY   = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign oDONE   = (state_q == S_DONE);
  assign oMA_SEL = mode_q;
  assign oMA_A0  = a0_q;
  assign oMA_A1  = a1_q;
  assign oMA_B0  = b0_q;
  assign oMA_B1  = b1_q;
  assign oACC    = acc_q;
  assign oOVF    = ovf_q;

endmodule

// File: tb/tb_multadd_dot_seq.sv
// Directed bench for multadd_dot_seq with a single-cycle multiply-add model.
// Latency: checks oDONE arrives two cycles after the last transfer.
// Backpressure: exercises iVALID gaps, ignored starts and mid-job reset.
module tb_multadd_dot_seq;

  logic        iCLK;
  logic        iRST_N;
  logic        iSTART;
  logic [7:0]  iLEN;
  logic        iMODE;
  logic        iVALID;
  logic        oREADY;
  logic [7:0]  iA0, iA1, iB0, iB1;
  logic        oMA_SEL;
  logic [7:0]  oMA_A0, oMA_A1, oMA_B0, oMA_B1;
  logic [16:0] iMA_RES;
  logic        oBUSY;
  logic        oDONE;
  logic [23:0] oACC;
  logic        oOVF;

  int checks   = 0;
  int failures = 0;

  multadd_dot_seq #(.LEN_W(8), .MA_LAT(1), .ACC_W(24)) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iSTART  (iSTART),
    .iLEN    (iLEN),
    .iMODE   (iMODE),
    .iVALID  (iVALID),
    .oREADY  (oREADY),
    .iA0     (iA0),
    .iA1     (iA1),
    .iB0     (iB0),
    .iB1     (iB1),
    .oMA_SEL (oMA_SEL),
    .oMA_A0  (oMA_A0),
    .oMA_A1  (oMA_A1),
    .oMA_B0  (oMA_B0),
    .oMA_B1  (oMA_B1),
    .iMA_RES (iMA_RES),
    .oBUSY   (oBUSY),
    .oDONE   (oDONE),
    .oACC    (oACC),
    .oOVF    (oOVF)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // External multiply-add unit with one cycle from operand registers to result.
  logic [16:0] p0, p1;
  always_comb begin
    p0 = 17'(oMA_A0) * 17'(oMA_B0);
    p1 = 17'(oMA_A1) * 17'(oMA_B1);
    iMA_RES = oMA_SEL ? (p0 - p1) : (p0 + p1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic start_job(input logic [7:0] len, input logic mode);
    iSTART = 1'b1;
    iLEN   = len;
    iMODE  = mode;
    tick();
    iSTART = 1'b0;
  endtask

  task automatic send(input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] b0, input logic [7:0] b1);
    iVALID = 1'b1;
    iA0 = a0; iA1 = a1; iB0 = b0; iB1 = b1;
    tick();
    iVALID = 1'b0;
  endtask

  task automatic gap(input logic [7:0] junk);
    iVALID = 1'b0;
    iA0 = junk; iA1 = junk; iB0 = junk; iB1 = junk;
    tick();
  endtask

  // Counts cycles from the last transfer (the send already consumed one) until oDONE.
  task automatic wait_done(output int lat);
    lat = 1;
    while (oDONE !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen_done;

    iRST_N = 1'b0;
    iSTART = 1'b0; iLEN = '0; iMODE = 1'b0; iVALID = 1'b0;
    iA0 = '0; iA1 = '0; iB0 = '0; iB1 = '0;
    tick();
    check("rst_ready", oREADY, 0);
    check("rst_busy",  oBUSY,  0);
    check("rst_done",  oDONE,  0);
    check("rst_acc",   oACC,   0);
    check("rst_ovf",   oOVF,   0);
    check("rst_sel",   oMA_SEL, 0);
    check("rst_ma",    {oMA_A0, oMA_A1, oMA_B0, oMA_B1}, 0);
    iRST_N = 1'b1;
    tick();

    // T1: add mode, back-to-back quads: 13 + 29 = 42.
    start_job(8'd2, 1'b0);
    check("t1_ready_run", oREADY, 1);
    check("t1_busy_run",  oBUSY,  1);
    send(8'd3, 8'd2, 8'd3, 8'd2);
    send(8'd5, 8'd2, 8'd5, 8'd2);
    check("t1_ma_ops", {oMA_A0, oMA_A1, oMA_B0, oMA_B1}, 32'h05020502);
    check("t1_ready_drain", oREADY, 0);
    check("t1_busy_drain",  oBUSY,  1);
    wait_done(lat);
    check("t1_done_lat", lat, 2);
    check("t1_acc", oACC, 42);
    check("t1_ovf", oOVF, 0);
    check("t1_busy_done", oBUSY, 0);
    tick();
    check("t1_done_once", oDONE, 0);
    check("t1_acc_held", oACC, 42);

    // T2: subtract mode: 21 + (-12) = 9.
    start_job(8'd2, 1'b1);
    check("t2_sel_start", oMA_SEL, 1);
    send(8'd5, 8'd2, 8'd5, 8'd2);
    check("t2_sel_mid", oMA_SEL, 1);
    send(8'd2, 8'd4, 8'd2, 8'd4);
    wait_done(lat);
    check("t2_done_lat", lat, 2);
    check("t2_acc", oACC, 9);
    check("t2_ovf", oOVF, 0);
    check("t2_sel_end", oMA_SEL, 1);
    tick();

    // T3: iVALID pattern 1,0,0,1,0,1; gaps carry junk that must not reach oMA_*.
    start_job(8'd3, 1'b0);
    send(8'd1, 8'd1, 8'd1, 8'd1);
    gap(8'd7);
    check("t3_ready_gap1", oREADY, 1);
    check("t3_ma_hold", oMA_A0, 1);
    gap(8'd9);
    check("t3_ready_gap2", oREADY, 1);
    send(8'd1, 8'd1, 8'd1, 8'd1);
    gap(8'd7);
    check("t3_ready_gap3", oREADY, 1);
    check("t3_no_early_done", oDONE, 0);
    send(8'd1, 8'd1, 8'd1, 8'd1);
    wait_done(lat);
    check("t3_done_lat", lat, 2);
    check("t3_acc", oACC, 6);
    tick();

    // T4: zero-length job goes straight to DONE and clears the accumulator.
    start_job(8'd0, 1'b0);
    check("t4_zero_done", oDONE, 1);
    check("t4_zero_acc", oACC, 0);
    check("t4_zero_ready", oREADY, 0);
    tick();
    check("t4_zero_idle", oDONE, 0);
    // A start during RUN must not change the job length.
    start_job(8'd2, 1'b0);
    iSTART = 1'b1; iLEN = 8'd5;
    send(8'd1, 8'd1, 8'd1, 8'd1);
    iSTART = 1'b0;
    send(8'd1, 8'd1, 8'd1, 8'd1);
    wait_done(lat);
    check("t4_run_start_lat", lat, 2);
    check("t4_run_start_acc", oACC, 4);
    // A start in the DONE cycle is ignored too.
    iSTART = 1'b1; iLEN = 8'd1;
    tick();
    iSTART = 1'b0;
    check("t4_done_start_busy", oBUSY, 0);
    check("t4_done_start_acc", oACC, 4);
    tick();

    // T5: 130 x 130050 = 16906500, wraps to 129284 with overflow.
    start_job(8'd130, 1'b0);
    for (int i = 0; i < 130; i++) begin
      send(8'd255, 8'd255, 8'd255, 8'd255);
    end
    wait_done(lat);
    check("t5_done_lat", lat, 2);
    check("t5_acc", oACC, 129284);
    check("t5_ovf", oOVF, 1);
    tick();
    start_job(8'd1, 1'b0);
    check("t5_ovf_cleared", oOVF, 0);
    send(8'd1, 8'd1, 8'd1, 8'd1);
    wait_done(lat);
    check("t5_next_acc", oACC, 2);
    tick();

    // T6: reset after the first of four quads discards the job.
    start_job(8'd4, 1'b0);
    send(8'd2, 8'd3, 8'd4, 8'd5);
    #2;
    iRST_N = 1'b0;
    #1;
    check("t6_rst_busy",  oBUSY,  0);
    check("t6_rst_ready", oREADY, 0);
    check("t6_rst_done",  oDONE,  0);
    check("t6_rst_acc",   oACC,   0);
    check("t6_rst_ovf",   oOVF,   0);
    check("t6_rst_ma",    {oMA_A0, oMA_A1, oMA_B0, oMA_B1}, 0);
    tick();
    tick();
    iRST_N = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (oDONE === 1'b1) seen_done++;
    end
    check("t6_no_done", seen_done, 0);
    // Fresh subtract job: 1 - 9 = -8 sign-extended to 24 bits.
    start_job(8'd1, 1'b1);
    send(8'd1, 8'd3, 8'd1, 8'd3);
    wait_done(lat);
    check("t6_fresh_lat", lat, 2);
    check("t6_fresh_acc", oACC, 32'h00FFFFF8);
    check("t6_fresh_ovf", oOVF, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
